// File: rtl/cmp_pkg.sv
// Shared definitions for the chunked magnitude comparator: result codes and FSM states.
package cmp_pkg;

    localparam logic signed [1:0] CMP_LT = 2'sb11;
    localparam logic signed [1:0] CMP_EQ = 2'sb00;
    localparam logic signed [1:0] CMP_GT = 2'sb01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic signed [1:0] cmp_code(input logic lt_in);
        return lt_in ? CMP_LT : CMP_GT;
    endfunction

endpackage

// File: rtl/comparator_chunked_if.sv
// Start/done handshake and result bus between the ALU controller and comparator_chunked.
interface comparator_chunked_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = $clog2(NCHUNK + 1);

    logic                    start;
    logic                    signed_mode;
    logic [WIDTH-1:0]        A;
    logic [WIDTH-1:0]        B;
    logic                    busy;
    logic                    done;
    logic signed [1:0]       comp_out;
    logic                    lt;
    logic                    gt;
    logic [CNTW-1:0]         cyc_cnt;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, comp_out, lt, gt, cyc_cnt
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, comp_out, lt, gt, cyc_cnt
    );
endinterface

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit unsigned magnitude compare.
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end
endmodule

// File: rtl/comparator_chunked.sv
// Multi-cycle MSB-first signed/unsigned magnitude comparator, CHUNK bits per cycle.
// Define CMP_EARLY_EXIT_EN to stop at the first differing chunk; otherwise all chunks are scanned.
module comparator_chunked
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    comparator_chunked_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = $clog2(NCHUNK + 1);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt;
    logic [WIDTH-1:0]   b_q, b_nxt;
    logic [IDXW-1:0]    idx, idx_nxt;
    logic [CNTW-1:0]    cnt, cnt_nxt;
    logic signed [1:0]  res, res_nxt;
    logic               load_out;

    logic signed [1:0]  comp_q;
    logic               lt_q, gt_q;
    logic [CNTW-1:0]    cyc_q;

    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic               c_lt, c_eq, c_gt;

    // Select the active chunk pair; a single narrow comparator is shared by all chunks.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            cnt   <= '0;
            res   <= CMP_EQ;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            res   <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        res_nxt   = res;
        load_out  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    // Signed mode is folded into the operands at capture by biasing the MSB.
                    state_nxt = CMP;
                    a_nxt     = bus.A ^ (bus.signed_mode ? MSB_MASK : '0);
                    b_nxt     = bus.B ^ (bus.signed_mode ? MSB_MASK : '0);
                    idx_nxt   = IDX_LAST;
                    cnt_nxt   = '0;
                    res_nxt   = CMP_EQ;
                end
            end
            CMP: begin
                cnt_nxt = cnt + CNTW'(1);
`ifdef CMP_EARLY_EXIT_EN
                if (!c_eq) begin
                    res_nxt   = cmp_code(c_lt);
                    state_nxt = DONE;
                    load_out  = 1'b1;
                end else if (idx == '0) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
`else
                if (!c_eq && (res == CMP_EQ)) begin
                    res_nxt = cmp_code(c_lt);
                end
                if (idx == '0) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_q <= CMP_EQ;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            cyc_q  <= '0;
        end else if (load_out) begin
            comp_q <= res_nxt;
            lt_q   <= (res_nxt == CMP_LT);
            gt_q   <= (res_nxt == CMP_GT);
            cyc_q  <= cnt_nxt;
        end
    end

    assign bus.busy     = (state == CMP);
    assign bus.done     = (state == DONE);
    assign bus.comp_out = comp_q;
    assign bus.lt       = lt_q;
    assign bus.gt       = gt_q;
    assign bus.cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_comparator_chunked.sv
// Directed table-driven bench for comparator_chunked (WIDTH=16, CHUNK=4), either build.
module tb_comparator_chunked;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int LIMIT  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    comparator_chunked_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    comparator_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              mode;
        logic [15:0]       a;
        logic [15:0]       b;
        logic signed [1:0] exp;
        int                n_ee;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int chunks_used(input int n_ee);
`ifdef CMP_EARLY_EXIT_EN
        return n_ee;
`else
        return NCHUNK;
`endif
    endfunction

    // Counts edges from the current point until done is seen.
    task automatic wait_done(input string nm, input int n);
        int edges = 0;
        while (bus.done !== 1'b1 && edges < LIMIT) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({nm, "_latency"}, edges, n);
    endtask

    task automatic check_result(input string nm, input logic signed [1:0] e, input int n);
        chk({nm, "_done"}, int'(bus.done), 1);
        chk({nm, "_comp"}, int'(bus.comp_out), int'(e));
        chk({nm, "_lt"}, int'(bus.lt), (e == -2'sd1) ? 1 : 0);
        chk({nm, "_gt"}, int'(bus.gt), (e == 2'sd1) ? 1 : 0);
        chk({nm, "_cnt"}, int'(bus.cyc_cnt), n);
    endtask

    task automatic launch(input logic m, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = m;
        bus.A           = a;
        bus.B           = b;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.signed_mode = ~m;
        bus.A           = 16'h5A5A;
        bus.B           = 16'hA5A5;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        n = chunks_used(v.n_ee);
        launch(v.mode, v.a, v.b);
        chk({v.name, "_busy"}, int'(bus.busy), 1);
        wait_done(v.name, n);
        check_result(v.name, v.exp, n);
        @(posedge clk);
        #1;
        chk({v.name, "_pulse"}, int'(bus.done), 0);
        chk({v.name, "_hold"}, int'(bus.comp_out), int'(v.exp));
    endtask

    initial begin
        vecs[0]  = '{"s_m1_p1",   1'b1, 16'hFFFF, 16'h0001, -2'sd1, 1};
        vecs[1]  = '{"u_ffff_1",  1'b0, 16'hFFFF, 16'h0001,  2'sd1, 1};
        vecs[2]  = '{"s_eq",      1'b1, 16'h1234, 16'h1234,  2'sd0, 4};
        vecs[3]  = '{"u_eq",      1'b0, 16'h1234, 16'h1234,  2'sd0, 4};
        vecs[4]  = '{"s_min_max", 1'b1, 16'h8000, 16'h7FFF, -2'sd1, 1};
        vecs[5]  = '{"u_lsb_gt",  1'b0, 16'h1235, 16'h1234,  2'sd1, 4};
        vecs[6]  = '{"s_lsb_gt",  1'b1, 16'h1235, 16'h1234,  2'sd1, 4};
        vecs[7]  = '{"s_0_m1",    1'b1, 16'h0000, 16'hFFFF,  2'sd1, 1};
        vecs[8]  = '{"u_chunk2",  1'b0, 16'h1334, 16'h1234,  2'sd1, 2};
        vecs[9]  = '{"u_chunk1",  1'b0, 16'h12A4, 16'h12B4, -2'sd1, 3};
        vecs[10] = '{"u_sticky",  1'b0, 16'h2F00, 16'h1FFF,  2'sd1, 1};
        vecs[11] = '{"s_max_min", 1'b1, 16'h7FFF, 16'h8000,  2'sd1, 1};

        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A           = '0;
        bus.B           = '0;

        #12;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_comp", int'(bus.comp_out), 0);
        chk("rst_lt",   int'(bus.lt), 0);
        chk("rst_gt",   int'(bus.gt), 0);
        chk("rst_cnt",  int'(bus.cyc_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i]);
        end

        // start during CMP is ignored: result and latency belong to the first operands
        begin
            launch(1'b0, 16'h1234, 16'h1234);
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = 16'h0000;
            bus.B     = 16'hFFFF;
            @(negedge clk);
            bus.start = 1'b0;
        end
        begin
            int edges = 0;
            while (bus.done !== 1'b1 && edges < LIMIT) begin
                @(posedge clk);
                #1;
                edges++;
            end
            chk("ign_latency", edges + 1, chunks_used(4));
            check_result("ign", 2'sd0, chunks_used(4));
        end
        repeat (2) @(posedge clk);

        // back-to-back: start held high during DONE
        begin
            int n1;
            int n2;
            n1 = chunks_used(1);
            n2 = chunks_used(4);
            launch(1'b1, 16'hFFFF, 16'h0001);
            wait_done("b2b1", n1);
            check_result("b2b1", -2'sd1, n1);
            bus.start       = 1'b1;
            bus.signed_mode = 1'b0;
            bus.A           = 16'h1235;
            bus.B           = 16'h1234;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.A     = 16'h0000;
            bus.B     = 16'hFFFF;
            chk("b2b2_busy", int'(bus.busy), 1);
            wait_done("b2b2", n2);
            check_result("b2b2", 2'sd1, n2);
        end
        repeat (2) @(posedge clk);

        // async reset during the second CMP cycle abandons the operation
        begin
            bit seen = 1'b0;
            launch(1'b0, 16'h1234, 16'h1234);
            @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("arst_busy", int'(bus.busy), 0);
            chk("arst_done", int'(bus.done), 0);
            chk("arst_comp", int'(bus.comp_out), 0);
            chk("arst_gt",   int'(bus.gt), 0);
            chk("arst_cnt",  int'(bus.cyc_cnt), 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (bus.done === 1'b1) seen = 1'b1;
            end
            chk("arst_no_done", int'(seen), 0);
        end
        run_op('{"post_rst", 1'b0, 16'h0003, 16'h0005, -2'sd1, 4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_chunked.md
# comparator_chunked

Parametrised, multi-cycle magnitude comparator for the low-power ALU datapath. It replaces the single-cycle 16-bit signed comparator with a WIDTH-bit unit that handles both signed and unsigned operands. The unit compares operands MSB-first, CHUNK bits per cycle, so only one narrow comparator toggles per clock. It sits beside the ALU operation units and uses a start/done handshake with the ALU controller.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (derived, localparam), WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- A  in  WIDTH  operand A; captured with start.
- B  in  WIDTH  operand B; captured with start.
- busy  out  1  high while in CMP.
- done  out  1  one-cycle pulse when the result is updated.
- comp_out  out  2 (signed)  result: -1 when A<B, +1 when A>B, 0 when A=B.
- lt, gt  out  1  decoded result flags.
- cyc_cnt  out  $clog2(NCHUNK+1)  number of chunk cycles used by the last operation.

## Operation
- FSM states are IDLE, CMP and DONE.
- IDLE → CMP on start:
  - Latch A, B and signed_mode.
  - Set idx = NCHUNK-1 and cnt = 0.
  - Clear the sticky result to EQ.
- Signed mode: invert bit WIDTH-1 of both latched operands (bias). An unsigned compare of the biased values then gives the signed ordering.
- Each CMP cycle: compare chunk[idx] of A against chunk[idx] of B as unsigned values, and increment cnt.
  - Unequal, with early exit built in: load LT or GT and go to DONE.
  - Unequal, without early exit: load LT or GT into the sticky result only if it still holds EQ.
  - Equal with idx==0, or any chunk with idx==0 when early exit is not built in: go to DONE.
  - Otherwise: idx decrements and the FSM stays in CMP.
- DONE:
  - done=1 for this cycle only.
  - comp_out, lt, gt and cyc_cnt are registered from the sticky result and cnt on entry to DONE, and are valid during this cycle.
  - start=1 → CMP with new operands (back-to-back). Otherwise → IDLE.
- Results hold their value until the next DONE.
- start while in CMP is ignored; it is not queued.
- Only one of lt/gt is ever high; both low means equal.

## Timing
- Reset values: busy=0, done=0, comp_out=0, lt=0, gt=0, cyc_cnt=0, state=IDLE.
- There is no valid result before the first done.
- start is sampled at edge k; busy rises after edge k.
- Latency: done is high in cycle k+N+1, where N = number of chunks examined.
  - Early exit: N is 1..NCHUNK.
  - Otherwise: N = NCHUNK always.
- Throughput with back-to-back start in DONE: one result every N+1 cycles.
- rst asserted mid-operation: all outputs go to reset values immediately, asynchronously, and the operation is abandoned. The first start after rst deasserts is serviced normally.
- Operands are not required to be stable after the start cycle.

## Configuration
- CMP_EARLY_EXIT_EN defined: terminate at the first differing chunk. Latency and power are data-dependent.
- CMP_EARLY_EXIT_EN not defined: always scan all NCHUNK chunks. Latency is constant NCHUNK+1, as required for timing-deterministic ALU scheduling.
- comp_out is identical in both builds; only cyc_cnt and done timing differ.

## Structure
- Package cmp_pkg:
  - Result constants CMP_LT=2'sb11, CMP_EQ=2'sb00, CMP_GT=2'sb01.
  - The state enum {IDLE, CMP, DONE}.
- Sub-module chunk_cmp: combinational CHUNK-bit unsigned compare producing lt/eq/gt. It is instantiated once and fed through an idx-driven mux.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, built with CMP_EARLY_EXIT_EN unless stated.
- signed_mode=1, A=16'hFFFF (-1), B=16'h0001 → comp_out=-1, lt=1, cyc_cnt=1, done 2 cycles after start.
- signed_mode=0, same A and B → comp_out=+1, gt=1, cyc_cnt=1.
- A=B=16'h1234, either mode → comp_out=0, lt=gt=0, cyc_cnt=4, done 5 cycles after start.
- signed_mode=1, A=16'h8000, B=16'h7FFF → comp_out=-1. A=16'h1235, B=16'h1234 → comp_out=+1, cyc_cnt=4.
- Build without the macro: A=16'hFFFF, B=16'h0001 signed → comp_out=-1, cyc_cnt=4, done 5 cycles after start. Back-to-back start in DONE gives the next done 5 cycles later.
- rst pulsed during the 2nd CMP cycle of the A=B=16'h1234 case → busy=done=comp_out=0 at once, no done pulse. The next start with A=3, B=5 unsigned → comp_out=-1, cyc_cnt=4.
